i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

I2S serializer that drives the codec DAC data pin (AC_GPIO0) from 16-bit left/right headphone samples, in the `clk_48` domain. The codec is the I2S clock master and supplies BCLK and LRCLK on AC_GPIO2/AC_GPIO3. The block sits between the filter/mux output (`headphone_left`/`headphone_right`) and the codec pin. It accepts one stereo sample per frame through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16: sample width, sent MSB first.
- `SYNC_STAGES`, 2: flip-flop stages on the `bclk`/`lrclk` synchronizers (≥2).
- `TIMEOUT`, 1024: `clk_48` cycles with no BCLK falling edge before lock is dropped.
- `clk_48`  in  1  system clock (48 MHz); all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bclk`  in  1  codec bit clock, asynchronous.
- `lrclk`  in  1  codec word clock, asynchronous; low = left, high = right.
- `left_in`  in  DATA_WIDTH  left sample, two's complement.
- `right_in`  in  DATA_WIDTH  right sample, two's complement.
- `sample_valid`  in  1  the sample pair is valid.
- `sample_ready`  out  1  the holding register is empty.
- `sdata`  out  1  serial data to the codec DAC.
- `frame_start`  out  1  one-cycle pulse at each left-channel boundary while locked.
- `underrun`  out  1  one-cycle pulse at a frame boundary when no new sample was held.
- `locked`  out  1  the block is in RUN.

## Operation
- **Synchronizers:** `bclk` and `lrclk` each pass through `SYNC_STAGES` flops. A further flop on `bclk` produces `bclk_fall`, which is synced-prev=1 and synced=0.
- **LRCLK tracking:** `lrclk` is sampled only on `bclk_fall` into `lr_prev`. A boundary is `bclk_fall` with synced `lrclk` ≠ `lr_prev`. A left boundary ends with `lrclk`=0; a right boundary ends with `lrclk`=1.
- **Handshake:** `sample_valid & sample_ready` captures `left_in`/`right_in` into `hold_l`/`hold_r` and sets `hold_full`. `sample_ready` = ~`hold_full`. While `hold_full`=1, valid is ignored and the input data is not captured.
- **FSM, IDLE:**
  - `sdata`=0, `locked`=0.
  - Goes to RUN on the first left boundary. That first boundary is processed as a RUN left boundary in the same cycle.
- **FSM, RUN:**
  - **Left boundary:**
    - `frame_start` pulses.
    - If `hold_full`=1: `act_l`/`act_r` ← `hold_l`/`hold_r` and `hold_full` clears.
    - Else: `underrun` pulses and `act_l`/`act_r` keep their previous values (the last frame repeats).
    - The shift register loads the new `act_l`.
  - **Right boundary:** the shift register loads `act_r`.
  - **Boundary bit:** on a boundary `bclk_fall`, `sdata` ← 0. This is the I2S one-bit delay: the MSB goes out on the next fall.
  - **Other `bclk_fall`:** `sdata` ← `shift[MSB]`, then shift left with 0 fill. Bits past `DATA_WIDTH` in a slot are therefore 0.
  - **Short slots:** if a slot is shorter than DATA_WIDTH+1 bits, the word is truncated at the next boundary.
  - **Loss of lock:** a timeout counter clears on every `bclk_fall` and increments otherwise. When it reaches `TIMEOUT`, the FSM goes to IDLE and `sdata` ← 0. `hold` contents are kept.
- **Capture at a boundary:** if a capture and a left boundary occur in the same cycle with `hold_full`=0, the new sample goes to `hold` (used next frame) and `underrun` still pulses.
- **Reset values:** `sdata`=0, `frame_start`=0, `underrun`=0, `locked`=0, `sample_ready`=1, `hold_full`=0, `act_l`=`act_r`=0, shift register 0, `lr_prev`=0, timeout counter 0, synchronizers 0, FSM = IDLE. `rst` mid-slot aborts the word immediately; the block resumes only at the next left boundary.

## Timing
- **BCLK-to-data latency:** pin BCLK fall to `sdata` change is `SYNC_STAGES`+2 `clk_48` cycles (4 cycles, 83 ns, at the default).
- **BCLK constraint:** BCLK high and low phases must each be ≥ `SYNC_STAGES`+2 cycles. 3.072 MHz (≈7.8 cycles per phase) is supported.
- **Pulse alignment:** `frame_start` and `underrun` are registered and high for exactly one cycle, the same cycle that `sdata` takes the boundary 0.
- **Handshake timing:** `sample_ready` goes low in the cycle after capture. It returns high in the cycle after the left boundary that consumes `hold`. At most one new sample pair is accepted per frame.
- **Timeout:** drop-out occurs `TIMEOUT` cycles after the last `bclk_fall`.

## Test plan
- **Reset:** hold `rst` 3 cycles with BCLK toggling -> `sdata`=0, `sample_ready`=1, `locked`=0, no pulses during or after until the first left boundary.
- **Serialization:**
  - Stimulus: capture L=16'hA5F0, R=16'h0F0F. BCLK period 16 cycles, 32-bit slots, start with LRCLK=1.
  - Required: at the first left boundary `locked`=1 and `frame_start` pulses. The left slot reads 0, 1010010111110000, then 15 zeros. The right slot reads 0, 0000111100001111, then 15 zeros.
- **Backpressure:** capture 16'h1111/16'h2222, then assert valid with 16'h3333/16'h4444 while `hold_full` -> `sample_ready`=0 and the second pair is not taken. At the left boundary the frame carries 1111/2222 and `sample_ready` returns to 1.
- **Underrun:** no valid for one frame -> `underrun` is a single-cycle pulse at the left boundary and the previous L/R words are retransmitted bit-exact.
- **Lock loss:** stop BCLK for 1100 cycles -> `locked` drops at cycle 1024 and `sdata`=0. Restart mid right slot -> `sdata` stays 0 until the next left boundary.
- **Reset mid-word:** assert `rst` at bit 5 of the left slot -> `sdata`=0 the next cycle and all outputs reach their reset values. After release, transmission restarts at the next left boundary with `act`=0 and `underrun` pulses if nothing was captured.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx
//
// I2S serializer for the codec DAC data pin. The codec is the I2S clock
// master: BCLK and LRCLK arrive asynchronously and are resynchronized into
// the clk_48 domain. One stereo sample pair per frame is accepted through a
// valid/ready handshake into a holding register. The pair is moved into the
// active registers at each left-channel boundary. Each slot is sent MSB
// first, after the standard I2S one-bit delay.
//
// Ports
//   i_clk_48          system clock, all logic on its rising edge
//   i_rst             synchronous active-high reset
//   i_bclk            codec bit clock (asynchronous)
//   i_lrclk           codec word clock (asynchronous), 0 = left, 1 = right
//   i_left_in         left sample, two's complement
//   i_right_in        right sample, two's complement
//   i_sample_valid    sample pair on i_left_in/i_right_in is valid
//   o_sample_ready    holding register is empty
//   o_sdata           serial data to the codec DAC
//   o_frame_start     one-cycle pulse at each left boundary while locked
//   o_underrun        one-cycle pulse at a left boundary with nothing held
//   o_locked          serializer is running in step with the codec clocks
// ---------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                  i_clk_48,
    input  logic                  i_rst,
    input  logic                  i_bclk,
    input  logic                  i_lrclk,
    input  logic [DATA_WIDTH-1:0] i_left_in,
    input  logic [DATA_WIDTH-1:0] i_right_in,
    input  logic                  i_sample_valid,
    output logic                  o_sample_ready,
    output logic                  o_sdata,
    output logic                  o_frame_start,
    output logic                  o_underrun,
    output logic                  o_locked
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Synchronizers and edge detection
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrclk_sync;
    logic                   r_bclk_prev;
    logic                   r_bclk_fall;
    logic                   w_bclk_s;
    logic                   w_lrclk_s;

    // Frame tracking and datapath
    state_e                 r_state;
    logic                   r_lr_prev;
    logic [CntW-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]  r_hold_l;
    logic [DATA_WIDTH-1:0]  r_hold_r;
    logic                   r_hold_full;
    logic [DATA_WIDTH-1:0]  r_act_l;
    logic [DATA_WIDTH-1:0]  r_act_r;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_sdata;
    logic                   r_frame_start;
    logic                   r_underrun;

    logic                   w_boundary;
    logic                   w_left_bnd;
    logic                   w_right_bnd;
    logic                   w_timeout;
    logic                   w_capture;

    assign w_bclk_s  = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrclk_s = r_lrclk_sync[SYNC_STAGES-1];

    // The fall strobe is registered so that pin-to-sdata latency is
    // SYNC_STAGES+2 cycles. LRCLK moves on the same BCLK fall and goes through
    // the same sync depth, so the synced LRCLK already holds the new value here.
    always_ff @(posedge i_clk_48) begin
        if (i_rst) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_bclk_prev  <= 1'b0;
            r_bclk_fall  <= 1'b0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
            r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], i_lrclk};
            r_bclk_prev  <= w_bclk_s;
            r_bclk_fall  <= r_bclk_prev & ~w_bclk_s;
        end
    end

    assign w_boundary  = r_bclk_fall & (w_lrclk_s != r_lr_prev);
    assign w_left_bnd  = w_boundary & ~w_lrclk_s;
    assign w_right_bnd = w_boundary & w_lrclk_s;
    // Never coincides with a fall, so it never competes with a boundary.
    assign w_timeout   = ~r_bclk_fall & (r_cnt == CntW'(TIMEOUT - 1));
    assign w_capture   = i_sample_valid & ~r_hold_full;

    always_ff @(posedge i_clk_48) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_lr_prev     <= 1'b0;
            r_cnt         <= '0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_hold_full   <= 1'b0;
            r_act_l       <= '0;
            r_act_r       <= '0;
            r_shift       <= '0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (r_bclk_fall) begin
                r_lr_prev <= w_lrclk_s;
            end

            // Saturates at TIMEOUT so it stays parked while idle.
            if (r_bclk_fall) begin
                r_cnt <= '0;
            end else if (r_cnt != CntW'(TIMEOUT)) begin
                r_cnt <= r_cnt + CntW'(1);
            end

            // Capture only when empty; a left boundary can only clear a full
            // holding register, so the two never fight over r_hold_full.
            if (w_capture) begin
                r_hold_l    <= i_left_in;
                r_hold_r    <= i_right_in;
                r_hold_full <= 1'b1;
            end

            if (w_left_bnd) begin
                // Taken from either state: the locking boundary is a real one.
                r_state       <= StRun;
                r_frame_start <= 1'b1;
                r_sdata       <= 1'b0;
                if (r_hold_full) begin
                    r_act_l     <= r_hold_l;
                    r_act_r     <= r_hold_r;
                    r_shift     <= r_hold_l;
                    r_hold_full <= 1'b0;
                end else begin
                    // Repeat the previous frame.
                    r_underrun <= 1'b1;
                    r_shift    <= r_act_l;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_sdata <= 1'b0;
                    end
                    StRun: begin
                        if (w_timeout) begin
                            r_state <= StIdle;
                            r_sdata <= 1'b0;
                        end else if (w_right_bnd) begin
                            r_shift <= r_act_r;
                            r_sdata <= 1'b0;
                        end else if (r_bclk_fall) begin
                            r_sdata <= r_shift[DATA_WIDTH-1];
                            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_sdata <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sample_ready = ~r_hold_full;
    assign o_sdata        = r_sdata;
    assign o_frame_start  = r_frame_start;
    assign o_underrun     = r_underrun;
    assign o_locked       = (r_state == StRun);

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx
//
// Self-checking bench for i2s_dac_tx. The bench plays the codec: 16-cycle BCLK
// and 32-bit slots. It samples sdata on each BCLK rise. Expected slot words
// are queued when the stimulus is set up, then popped and compared as each
// slot completes.
// ---------------------------------------------------------------------------
module tb_i2s_dac_tx;

    logic        clk_48 = 1'b0;
    logic        rst    = 1'b1;
    logic        bclk   = 1'b1;
    logic        lrclk  = 1'b1;
    logic [15:0] left_in  = '0;
    logic [15:0] right_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sdata;
    logic        frame_start;
    logic        underrun;
    logic        locked;

    int n_checks = 0;
    int n_pass   = 0;
    int fs_cnt   = 0;
    int ur_cnt   = 0;
    int fs_run   = 0;
    int ur_run   = 0;
    int fs_max   = 0;
    int ur_max   = 0;

    logic [31:0] exp_q[$];

    i2s_dac_tx #(
        .DATA_WIDTH (16),
        .SYNC_STAGES(2),
        .TIMEOUT    (1024)
    ) dut (
        .i_clk_48      (clk_48),
        .i_rst         (rst),
        .i_bclk        (bclk),
        .i_lrclk       (lrclk),
        .i_left_in     (left_in),
        .i_right_in    (right_in),
        .i_sample_valid(sample_valid),
        .o_sample_ready(sample_ready),
        .o_sdata       (sdata),
        .o_frame_start (frame_start),
        .o_underrun    (underrun),
        .o_locked      (locked)
    );

    always #5 clk_48 = ~clk_48;

    // Pulse counters and run-length tracking, sampled away from the active edge.
    always @(negedge clk_48) begin
        if (frame_start) begin
            fs_cnt = fs_cnt + 1;
            fs_run = fs_run + 1;
        end else begin
            fs_run = 0;
        end
        if (underrun) begin
            ur_cnt = ur_cnt + 1;
            ur_run = ur_run + 1;
        end else begin
            ur_run = 0;
        end
        if (fs_run > fs_max) fs_max = fs_run;
        if (ur_run > ur_max) ur_max = ur_run;
    end

    // One BCLK period: fall (with new LRCLK), 8 low cycles, sample, 8 high.
    task automatic bclk_bit(input logic lr, output logic b);
        bclk  = 1'b0;
        lrclk = lr;
        repeat (8) @(negedge clk_48);
        b    = sdata;
        bclk = 1'b1;
        repeat (8) @(negedge clk_48);
    endtask

    task automatic send_bits(input logic lr, input int n, output logic [31:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            bclk_bit(lr, b);
            w = {w[30:0], b};
        end
    endtask

    task automatic send_slot(input logic lr, input string name);
        logic [31:0] w;
        logic [31:0] e;
        send_bits(lr, 32, w);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: slot got %h, scoreboard empty", name, w);
        end else begin
            e = exp_q.pop_front();
            if (w !== e) $display("FAIL %s: slot got %h, expected %h", name, w, e);
            else n_pass++;
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({1'b0, l, 15'b0});
        exp_q.push_back({1'b0, r, 15'b0});
    endtask

    task automatic capture(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk_48);
        sample_valid = 1'b1;
        left_in      = l;
        right_in     = r;
        @(negedge clk_48);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_48);
            bclk = ~bclk;
        end
        bclk = 1'b1;
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL rst_sdata: got %b, expected 0", sdata);
        else n_pass++;
        n_checks++;
        if (sample_ready !== 1'b1) $display("FAIL rst_ready: got %b, expected 1", sample_ready);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL rst_locked: got %b, expected 0", locked);
        else n_pass++;
        @(negedge clk_48);
        rst = 1'b0;
        // A right slot while idle: still silent and unlocked.
        exp_q.push_back(32'h0);
        send_slot(1'b1, "idle_slot");
        n_checks++;
        if (locked !== 1'b0) $display("FAIL idle_locked: got %b, expected 0", locked);
        else n_pass++;
        n_checks++;
        if (fs_cnt + ur_cnt !== 0)
            $display("FAIL rst_pulses: got %0d pulses, expected 0", fs_cnt + ur_cnt);
        else n_pass++;
    endtask

    task automatic test_serialization;
        int fs0;
        int ur0;
        capture(16'hA5F0, 16'h0F0F);
        n_checks++;
        if (sample_ready !== 1'b0) $display("FAIL ser_ready_low: got %b, expected 0", sample_ready);
        else n_pass++;
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        push_frame(16'hA5F0, 16'h0F0F);
        send_slot(1'b0, "ser_left");
        n_checks++;
        if (locked !== 1'b1) $display("FAIL ser_locked: got %b, expected 1", locked);
        else n_pass++;
        n_checks++;
        if (fs_cnt !== fs0 + 1) $display("FAIL ser_fs: got %0d, expected %0d", fs_cnt, fs0 + 1);
        else n_pass++;
        n_checks++;
        if (sample_ready !== 1'b1) $display("FAIL ser_ready_high: got %b, expected 1", sample_ready);
        else n_pass++;
        send_slot(1'b1, "ser_right");
        n_checks++;
        if (ur_cnt !== ur0) $display("FAIL ser_no_underrun: got %0d, expected %0d", ur_cnt, ur0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        capture(16'h1111, 16'h2222);
        @(negedge clk_48);
        sample_valid = 1'b1;
        left_in      = 16'h3333;
        right_in     = 16'h4444;
        repeat (3) @(negedge clk_48);
        n_checks++;
        if (sample_ready !== 1'b0) $display("FAIL bp_ready_low: got %b, expected 0", sample_ready);
        else n_pass++;
        sample_valid = 1'b0;
        push_frame(16'h1111, 16'h2222);
        send_slot(1'b0, "bp_left");
        n_checks++;
        if (sample_ready !== 1'b1) $display("FAIL bp_ready_high: got %b, expected 1", sample_ready);
        else n_pass++;
        send_slot(1'b1, "bp_right");
    endtask

    task automatic test_underrun;
        int ur0;
        int fs0;
        ur0 = ur_cnt;
        fs0 = fs_cnt;
        push_frame(16'h1111, 16'h2222);
        send_slot(1'b0, "ur_left");
        send_slot(1'b1, "ur_right");
        n_checks++;
        if (ur_cnt !== ur0 + 1) $display("FAIL ur_pulse: got %0d, expected %0d", ur_cnt, ur0 + 1);
        else n_pass++;
        n_checks++;
        if (fs_cnt !== fs0 + 1) $display("FAIL ur_fs: got %0d, expected %0d", fs_cnt, fs0 + 1);
        else n_pass++;
    endtask

    task automatic test_lock_loss;
        logic [31:0] w;
        int fs0;
        int ur0;
        repeat (1000) @(negedge clk_48);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL ll_still_locked: got %b, expected 1", locked);
        else n_pass++;
        repeat (100) @(negedge clk_48);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL ll_dropped: got %b, expected 0", locked);
        else n_pass++;
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL ll_sdata: got %b, expected 0", sdata);
        else n_pass++;
        capture(16'h5A5A, 16'hC3C3);
        // Restart in the middle of a right slot: no output until a left boundary.
        send_bits(1'b1, 16, w);
        n_checks++;
        if (w !== 32'h0) $display("FAIL ll_mid_right: got %h, expected 00000000", w);
        else n_pass++;
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        push_frame(16'h5A5A, 16'hC3C3);
        send_slot(1'b0, "ll_left");
        n_checks++;
        if (locked !== 1'b1) $display("FAIL ll_relock: got %b, expected 1", locked);
        else n_pass++;
        send_slot(1'b1, "ll_right");
        n_checks++;
        if (fs_cnt !== fs0 + 1 || ur_cnt !== ur0)
            $display("FAIL ll_pulses: got fs %0d ur %0d, expected fs %0d ur %0d",
                     fs_cnt, ur_cnt, fs0 + 1, ur0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_word;
        logic [31:0] w;
        int fs0;
        int ur0;
        send_bits(1'b0, 6, w);
        capture(16'h7777, 16'h8888);
        n_checks++;
        if (sample_ready !== 1'b0) $display("FAIL rmw_ready_low: got %b, expected 0", sample_ready);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk_48);
        n_checks++;
        if (sdata !== 1'b0 || locked !== 1'b0 || sample_ready !== 1'b1)
            $display("FAIL rmw_reset_vals: got sdata %b locked %b ready %b, expected 0 0 1",
                     sdata, locked, sample_ready);
        else n_pass++;
        @(negedge clk_48);
        rst = 1'b0;
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        send_bits(1'b0, 26, w);
        n_checks++;
        if (w !== 32'h0) $display("FAIL rmw_rest_left: got %h, expected 00000000", w);
        else n_pass++;
        exp_q.push_back(32'h0);
        send_slot(1'b1, "rmw_idle_right");
        push_frame(16'h0000, 16'h0000);
        send_slot(1'b0, "rmw_left");
        send_slot(1'b1, "rmw_right");
        n_checks++;
        if (ur_cnt !== ur0 + 1 || fs_cnt !== fs0 + 1)
            $display("FAIL rmw_pulses: got fs %0d ur %0d, expected fs %0d ur %0d",
                     fs_cnt, ur_cnt, fs0 + 1, ur0 + 1);
        else n_pass++;
    endtask

    task automatic test_pulse_width;
        n_checks++;
        if (fs_max !== 1) $display("FAIL fs_width: got %0d, expected 1", fs_max);
        else n_pass++;
        n_checks++;
        if (ur_max !== 1) $display("FAIL ur_width: got %0d, expected 1", ur_max);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_serialization();
        test_backpressure();
        test_underrun();
        test_lock_loss();
        test_reset_mid_word();
        test_pulse_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
